// File: rtl/i2s_master_tx.sv
// I2S master transmitter: derives BCLK/LRCLK from clk_i and shifts stereo words out MSB-first.
// Optional macro I2S_TX_HOLD_LAST_EN: on underrun, resend the last loaded word instead of zeros.
module i2s_master_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BCLK_DIV   = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] sample_data_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o,
    output logic                  frame_start_o,
    output logic                  underrun_o
);
    localparam int unsigned     KW      = $clog2(DATA_WIDTH);
    localparam int unsigned     DivW    = $clog2(BCLK_DIV);
    localparam logic [KW-1:0]   KLast   = KW'(DATA_WIDTH - 1);
    localparam logic [KW-1:0]   KHalf   = KW'(DATA_WIDTH / 2);
    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e                  state_q, state_d;
    logic [DivW-1:0]         div_q, div_d;
    logic                    bclk_q, bclk_d;
    logic [KW-1:0]           k_q, k_d, k_next;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0]   fill;
    logic                    fall, wrap, load, accept;
`ifdef I2S_TX_HOLD_LAST_EN
    logic [DATA_WIDTH-1:0]   last_q, last_d;
`endif

    assign fall   = (state_q != StIdle) && bclk_q && (div_q == DivLast);
    assign wrap   = fall && (state_q == StRun) && (k_q == KLast);
    assign load   = !reset_i && enable_i && ((state_q == StIdle) || wrap);
    assign accept = sample_valid_i && !hold_full_q;
    assign k_next = (k_q == KLast) ? '0 : k_q + KW'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable_i) state_d = StRun;
            StRun:   if (wrap && !enable_i) state_d = StStop;
            StStop:  if (fall) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sample_ready_o = !hold_full_q;
        bclk_o         = bclk_q;
        lrclk_o        = lrclk_q;
        sdata_o        = sdata_q;
        frame_start_o  = load;
        underrun_o     = load && (state_q == StRun) && !hold_full_q;
    end

    always_comb begin
        div_d       = div_q;
        bclk_d      = bclk_q;
        k_d         = k_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`ifdef I2S_TX_HOLD_LAST_EN
        last_d      = last_q;
        fill        = last_q;
`else
        fill        = '0;
`endif
        // An accept coinciding with a load keeps the new word for the following frame.
        if (accept) begin
            hold_d      = sample_data_i;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end

        if (state_q == StIdle) begin
            div_d   = '0;
            bclk_d  = 1'b0;
            k_d     = '0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
        end else begin
            if (div_q == DivLast) begin
                div_d  = '0;
                bclk_d = !bclk_q;
            end else begin
                div_d = div_q + DivW'(1);
            end
            if (fall) begin
                if (state_q == StStop) begin
                    k_d     = '0;
                    lrclk_d = 1'b0;
                    sdata_d = 1'b0;
                end else begin
                    // After the wrap's shift, the MSB holds R[0] of the outgoing frame.
                    k_d     = k_next;
                    lrclk_d = (k_next >= KHalf);
                    sdata_d = shift_q[DATA_WIDTH-1];
                    shift_d = shift_q << 1;
                end
            end
        end

        if (load) begin
            shift_d = hold_full_q ? hold_q : fill;
`ifdef I2S_TX_HOLD_LAST_EN
            if (hold_full_q) last_d = hold_q;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            k_q         <= '0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
            last_q      <= '0;
`endif
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            k_q         <= k_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`ifdef I2S_TX_HOLD_LAST_EN
            last_q      <= last_d;
`endif
        end
    end
endmodule
